// File: rtl/eau_compact.sv
`default_nettype none
// ============================================================================
// Module   : eau_compact
// Purpose  : Packs masked lanes densely using prefix-sum scatter offsets and
//            emits full N-lane beats plus a final partial beat.
// Revision : 1.0 - initial release
// ============================================================================
module eau_compact #(
  parameter int NW = 5,
  parameter int DW = 8,
  parameter int OW = 6,
  localparam int N = 1 << NW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0][DW-1:0]   in_data,
  input  logic [N-1:0]           in_mask,
  input  logic [N-1:0][OW-1:0]   in_psum,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0][DW-1:0]   out_data,
  output logic [NW:0]            out_count,
  output logic                   out_last
);

  localparam int BN = 2 * N - 1;
  localparam int MW = NW + 2;
  localparam int IW = OW + 1;
  localparam int CW = NW + 1;
  localparam logic [1:0] B_HOLD  = 2'd0;
  localparam logic [1:0] B_MERGE = 2'd1;
  localparam logic [1:0] B_SHIFT = 2'd2;
  localparam logic [1:0] B_CLEAR = 2'd3;
  localparam logic [CW-1:0] CNT_N = CW'(N);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [DW-1:0]      sbuf  [BN];
  logic [DW-1:0]      nbuf  [BN];
  logic [DW-1:0]      shbuf [BN];
  logic [IW-1:0]      idx   [N];
  logic [OW-1:0]      tot;
  logic [MW-1:0]      merged;
  logic               free, accept, flush_load;
  logic               emit, emit_last, src_flush;
  logic [CW-1:0]      emit_cnt;
  logic [1:0]         buf_sel;
  logic [N-1:0][DW-1:0] emit_data;

  assign free       = !out_valid || out_ready;
  assign in_ready   = (state == RUN) && free;
  assign accept     = in_valid && in_ready;
  assign flush_load = (state == FLUSH) && free;
  assign tot        = in_psum[N-1];
  assign merged     = MW'(cnt) + MW'(tot);

  // Destination slot for each lane: appended after the cnt entries already staged.
  for (genvar g = 0; g < N; g++) begin : g_idx
    assign idx[g] = IW'(cnt) + IW'(in_psum[g]) - IW'(1);
  end

  always_comb begin
    nbuf = sbuf;
    for (int k = 0; k < N; k++) begin
      if (in_mask[k] && (idx[k] < IW'(BN))) begin
        nbuf[idx[k][NW:0]] = in_data[k];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N - 1; j++) shbuf[j] = nbuf[j + N];
    for (int j = N - 1; j < BN; j++) shbuf[j] = '0;
  end

  always_comb begin
    emit      = 1'b0;
    emit_cnt  = '0;
    emit_last = 1'b0;
    src_flush = 1'b0;
    cnt_nx    = cnt;
    state_nx  = state;
    buf_sel   = B_HOLD;
    if (flush_load) begin
      emit      = 1'b1;
      emit_cnt  = cnt;
      emit_last = 1'b1;
      src_flush = 1'b1;
      cnt_nx    = '0;
      state_nx  = RUN;
      buf_sel   = B_CLEAR;
    end else if (accept) begin
      if (merged >= MW'(N)) begin
        emit      = 1'b1;
        emit_cnt  = CNT_N;
        emit_last = in_last && (merged == MW'(N));
        cnt_nx    = merged[CW-1:0] - CNT_N;
        buf_sel   = B_SHIFT;
        // Overflowing last beat: the remainder goes out as an extra beat.
        if (in_last && (merged > MW'(N))) state_nx = FLUSH;
      end else if (in_last) begin
        emit      = 1'b1;
        emit_cnt  = merged[CW-1:0];
        emit_last = 1'b1;
        cnt_nx    = '0;
        buf_sel   = B_CLEAR;
      end else begin
        cnt_nx    = merged[CW-1:0];
        buf_sel   = B_MERGE;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      emit_data[j] = (CW'(j) < emit_cnt) ? (src_flush ? sbuf[j] : nbuf[j]) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      for (int j = 0; j < BN; j++) sbuf[j] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      case (buf_sel)
        B_MERGE: sbuf <= nbuf;
        B_SHIFT: sbuf <= shbuf;
        B_CLEAR: for (int j = 0; j < BN; j++) sbuf[j] <= '0;
        default: ;
      endcase
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= emit_data;
        out_count <= emit_cnt;
        out_last  <= emit_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
